// File: rtl/pmod_switch_reader_if.sv
// rtl/pmod_switch_reader_if.sv - switch pins in, debounced levels and event strobes out
interface pmod_switch_reader_if #(
  parameter int N_SW = 2
);
  logic [N_SW-1:0] sw_in;
  logic [N_SW-1:0] sw_level;
  logic [N_SW-1:0] press_pulse;
  logic [N_SW-1:0] release_pulse;
  logic [N_SW-1:0] long_pulse;
  logic            tick;

  modport master (
    input  sw_in,
    output sw_level, press_pulse, release_pulse, long_pulse, tick
  );

  modport slave (
    output sw_in,
    input  sw_level, press_pulse, release_pulse, long_pulse, tick
  );
endinterface

// File: rtl/pmod_switch_reader.sv
// rtl/pmod_switch_reader.sv - push-switch synchroniser, tick-based debouncer and press/release/long-press events
module pmod_switch_reader #(
  parameter int N_SW           = 2,
  parameter int TICK_DIV       = 10000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int ACTIVE_LOW     = 0
) (
  input logic                 sys_clk,
  input logic                 reset,
  pmod_switch_reader_if.master sw_bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic              INVERT    = (ACTIVE_LOW != 0);
  localparam logic [N_SW-1:0]   IDLE_PIN  = INVERT ? '1 : '0;
  localparam logic              DEB_ONE   = (DEBOUNCE_TICKS == 1);
  localparam logic [PW-1:0]     PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]     PRE_TICK  = PW'(TICK_DIV - 2);
  localparam logic [DW-1:0]     DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]     HOLD_PRE  = HW'(LONG_TICKS - 2);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(LONG_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_HELD,
    S_LONG,
    S_DEB_REL
  } state_t;

  logic [PW-1:0]   pre_cnt;
  logic            tick_q;
  logic [N_SW-1:0] sync1;
  logic [N_SW-1:0] sync2;
  logic [N_SW-1:0] raw;

  state_t          state    [N_SW];
  logic [DW-1:0]   deb_cnt  [N_SW];
  logic [HW-1:0]   hold_cnt [N_SW];
  logic [N_SW-1:0] level_q;
  logic [N_SW-1:0] press_q;
  logic [N_SW-1:0] release_q;
  logic [N_SW-1:0] long_q;

  // tick is registered one count early so it is high while pre_cnt sits at TICK_DIV-1
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      tick_q  <= (pre_cnt == PRE_TICK);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= sw_bus.sw_in;
      sync2 <= sync1;
    end
  end

  assign raw = INVERT ? ~sync2 : sync2;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < N_SW; i++) begin
        state[i]    <= S_IDLE;
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      if (tick_q) begin
        for (int i = 0; i < N_SW; i++) begin
          case (state[i])
            S_IDLE: begin
              if (raw[i]) begin
                if (DEB_ONE) begin
                  state[i]    <= S_HELD;
                  level_q[i]  <= 1'b1;
                  press_q[i]  <= 1'b1;
                  hold_cnt[i] <= '0;
                end else begin
                  state[i]   <= S_DEB_PRESS;
                  deb_cnt[i] <= DW'(1);
                end
              end
            end
            S_DEB_PRESS: begin
              if (!raw[i]) begin
                state[i] <= S_IDLE;
              end else if (deb_cnt[i] == DEB_LAST) begin
                state[i]    <= S_HELD;
                level_q[i]  <= 1'b1;
                press_q[i]  <= 1'b1;
                hold_cnt[i] <= '0;
              end else begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
              end
            end
            S_HELD, S_LONG: begin
              if (!raw[i]) begin
                if (DEB_ONE) begin
                  state[i]     <= S_IDLE;
                  level_q[i]   <= 1'b0;
                  release_q[i] <= 1'b1;
                end else begin
                  state[i]   <= S_DEB_REL;
                  deb_cnt[i] <= DW'(1);
                end
              end else if (state[i] == S_HELD) begin
                // hold_cnt stops at LONG_TICKS-1, which also marks "came from LONG" for DEB_REL
                if (hold_cnt[i] == HOLD_PRE) begin
                  state[i]    <= S_LONG;
                  long_q[i]   <= 1'b1;
                  hold_cnt[i] <= HOLD_LAST;
                end else begin
                  hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
              end
            end
            S_DEB_REL: begin
              if (raw[i]) begin
                state[i] <= (hold_cnt[i] == HOLD_LAST) ? S_LONG : S_HELD;
              end else if (deb_cnt[i] == DEB_LAST) begin
                state[i]     <= S_IDLE;
                level_q[i]   <= 1'b0;
                release_q[i] <= 1'b1;
              end else begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
              end
            end
            default: state[i] <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign sw_bus.sw_level      = level_q;
  assign sw_bus.press_pulse   = press_q;
  assign sw_bus.release_pulse = release_q;
  assign sw_bus.long_pulse    = long_q;
  assign sw_bus.tick          = tick_q;

endmodule

// File: tb/tb_pmod_switch_reader.sv
// tb/tb_pmod_switch_reader.sv - directed vector bench for pmod_switch_reader
module tb_pmod_switch_reader;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 sys_clk = ~sys_clk;

  pmod_switch_reader_if #(.N_SW(2)) bus ();

  pmod_switch_reader #(
    .N_SW(2),
    .TICK_DIV(10),
    .DEBOUNCE_TICKS(4),
    .LONG_TICKS(20),
    .ACTIVE_LOW(0)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .sw_bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int press_tot [2] = '{0, 0};
  int rel_tot   [2] = '{0, 0};
  int long_tot  [2] = '{0, 0};

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus.press_pulse[i])   press_tot[i] = press_tot[i] + 1;
      if (bus.release_pulse[i]) rel_tot[i]   = rel_tot[i] + 1;
      if (bus.long_pulse[i])    long_tot[i]  = long_tot[i] + 1;
    end
  end

  typedef struct {
    logic [1:0] sw;
    int         hold;
    logic [1:0] exp_press;
    logic [1:0] exp_long;
    logic [1:0] exp_rel;
    logic [1:0] exp_lvl_held;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [1:0] sel(input int kind);
    case (kind)
      0:       return bus.press_pulse;
      1:       return bus.release_pulse;
      2:       return bus.long_pulse;
      default: return bus.sw_level;
    endcase
  endfunction

  // returns bound with seen=0 if the event never showed up
  task automatic wait_for(input int kind, input logic [1:0] mask, input int bound,
                          output int n, output logic [1:0] seen);
    n    = 0;
    seen = '0;
    while (n < bound) begin
      step();
      n++;
      seen = sel(kind) & mask;
      if (seen != 2'b00) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         n2;
    int         first_tick;
    int         bad_ticks;
    int         p0 [2];
    int         r0 [2];
    int         l0 [2];
    logic [1:0] seen;
    logic [1:0] lvl_held;
    logic       lvl_seen;

    vecs[0] = '{sw: 2'b01, hold: 300, exp_press: 2'b01, exp_long: 2'b01, exp_rel: 2'b01, exp_lvl_held: 2'b01};
    vecs[1] = '{sw: 2'b10, hold: 100, exp_press: 2'b10, exp_long: 2'b00, exp_rel: 2'b10, exp_lvl_held: 2'b10};
    vecs[2] = '{sw: 2'b11, hold: 60,  exp_press: 2'b11, exp_long: 2'b00, exp_rel: 2'b11, exp_lvl_held: 2'b11};
    vecs[3] = '{sw: 2'b01, hold: 25,  exp_press: 2'b00, exp_long: 2'b00, exp_rel: 2'b00, exp_lvl_held: 2'b00};
    vecs[4] = '{sw: 2'b10, hold: 45,  exp_press: 2'b10, exp_long: 2'b00, exp_rel: 2'b10, exp_lvl_held: 2'b10};
    vecs[5] = '{sw: 2'b11, hold: 250, exp_press: 2'b11, exp_long: 2'b11, exp_rel: 2'b11, exp_lvl_held: 2'b11};

    bus.sw_in = 2'b00;
    reset     = 1'b1;
    repeat (5) step();
    check("reset_level", bus.sw_level, 0);
    check("reset_press", bus.press_pulse, 0);
    check("reset_release", bus.release_pulse, 0);
    check("reset_long", bus.long_pulse, 0);
    check("reset_tick", bus.tick, 0);

    // prescaler: tick high in cycles 9, 19, 29, ... after reset release
    reset      = 1'b0;
    first_tick = 0;
    bad_ticks  = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (bus.tick && first_tick == 0) first_tick = c;
      if (bus.tick !== ((c % 10) == 9)) bad_ticks++;
    end
    check("tick_first", first_tick, 9);
    check("tick_pattern_errors", bad_ticks, 0);

    // clean press: latency, long press timing, release latency
    bus.sw_in = 2'b01;
    wait_for(3, 2'b01, 100, n, seen);
    check_range("press_latency", n, 33, 43);
    check("press_pulse_with_level", bus.press_pulse, 2'b01);
    wait_for(2, 2'b01, 300, n, seen);
    check("long_seen", seen, 2'b01);
    check_range("long_after_press", n, 190, 200);
    bus.sw_in = 2'b00;
    wait_for(1, 2'b01, 100, n, seen);
    check("release_seen", seen, 2'b01);
    check_range("release_latency", n, 33, 43);
    check("level_after_release", bus.sw_level, 0);
    repeat (20) step();

    // vector table: press phase, then 80 idle cycles
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 2; i++) begin
        p0[i] = press_tot[i];
        r0[i] = rel_tot[i];
        l0[i] = long_tot[i];
      end
      bus.sw_in = vecs[v].sw;
      repeat (vecs[v].hold) step();
      lvl_held  = bus.sw_level;
      bus.sw_in = 2'b00;
      repeat (80) step();
      check($sformatf("v%0d_level_held", v), lvl_held, vecs[v].exp_lvl_held);
      check($sformatf("v%0d_level_end", v), bus.sw_level, 0);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("v%0d_press%0d", v, i), press_tot[i] - p0[i], int'(vecs[v].exp_press[i]));
        check($sformatf("v%0d_long%0d", v, i), long_tot[i] - l0[i], int'(vecs[v].exp_long[i]));
        check($sformatf("v%0d_release%0d", v, i), rel_tot[i] - r0[i], int'(vecs[v].exp_rel[i]));
      end
    end

    // bounce: 15-cycle toggles never hold for four ticks
    p0[0]    = press_tot[0];
    r0[0]    = rel_tot[0];
    l0[0]    = long_tot[0];
    lvl_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.sw_in = {1'b0, ((c / 15) % 2) == 0};
      step();
      lvl_seen |= bus.sw_level[0];
    end
    bus.sw_in = 2'b00;
    for (int c = 0; c < 60; c++) begin
      step();
      lvl_seen |= bus.sw_level[0];
    end
    check("bounce_press", press_tot[0] - p0[0], 0);
    check("bounce_release", rel_tot[0] - r0[0], 0);
    check("bounce_long", long_tot[0] - l0[0], 0);
    check("bounce_level", lvl_seen, 0);

    // simultaneous press, independent releases
    bus.sw_in = 2'b11;
    wait_for(0, 2'b11, 80, n, seen);
    check("simul_press", seen, 2'b11);
    repeat (10) step();
    bus.sw_in = 2'b10;
    wait_for(1, 2'b11, 80, n, seen);
    check("simul_release0", seen, 2'b01);
    check("simul_level_mid", bus.sw_level, 2'b10);
    bus.sw_in = 2'b00;
    wait_for(1, 2'b11, 80, n, seen);
    check("simul_release1", seen, 2'b10);
    repeat (20) step();

    // reset one cycle after press_pulse, switch kept pressed
    bus.sw_in = 2'b01;
    wait_for(0, 2'b01, 80, n, seen);
    check("rst_mid_first_press", seen, 2'b01);
    step();
    r0[0] = rel_tot[0];
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_level", bus.sw_level, 0);
    check("rst_mid_pulses", {bus.press_pulse, bus.release_pulse, bus.long_pulse}, 0);
    wait_for(0, 2'b01, 60, n2, seen);
    check("rst_mid_repress", seen, 2'b01);
    check_range("rst_mid_repress_latency", n2, 1, 52);
    check("rst_mid_no_release", rel_tot[0] - r0[0], 0);
    bus.sw_in = 2'b00;
    repeat (80) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
